debug_probe_capture: RTL and testbench

- Parametrised on-chip capture engine for CommsFPGA debug signals (Manchester encoder/decoder state, MII nibbles, strobes).
- Selects one of NUM_CH probe buses and qualifies samples with a sample enable (e.g. clk1x_enable).
- Triggers on a masked value match, a match edge, or an external trigger, and records a pre/post-trigger window into a circular RAM.
- Readout is through a registered port for a register bank or JTAG bridge.

---
 rtl/debug_probe_capture.sv | 218 +++++++++++++++++++++
 tb/tb_debug_probe_capture.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_probe_capture.sv
// Probe capture engine: selects one probe bus, qualifies samples, triggers on a masked
// match / match edge / external trigger and records a pre/post window into a circular RAM.
module debug_probe_capture #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 16,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                   clk16x,
    input  logic                   reset_n,
    input  logic [NUM_CH*CH_W-1:0] probe_in,
    input  logic [SEL_W-1:0]       ch_sel,
    input  logic                   sample_en,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   trig_ext,
    input  logic [CH_W-1:0]        trig_mask,
    input  logic [CH_W-1:0]        trig_value,
    input  logic                   trig_edge,
    input  logic [ADDR_W-1:0]      pre_count,
    input  logic                   rd_en,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [CH_W-1:0]        rd_data,
    output logic                   rd_valid,
    output logic [2:0]             state_o,
    output logic                   triggered,
    output logic                   done,
    output logic [ADDR_W-1:0]      trig_ptr
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StFill = 3'd1;
    localparam logic [2:0] StWait = 3'd2;
    localparam logic [2:0] StPost = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    logic [2:0]        state_q, state_d;
    logic [SEL_W-1:0]  ch_sel_q, ch_sel_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
    logic              triggered_q, triggered_d;
    logic              done_q, done_d;
    logic              match_prev_q, match_prev_d;

    logic [CH_W-1:0]   sample_q;
    logic              samp_vld_q;
    logic              ext_q;

    logic [CH_W-1:0]   rd_data_q;
    logic              rd_valid_q;

    logic [CH_W-1:0]   mem [DEPTH];

    logic [CH_W-1:0]   sel_word;
    logic              arm_start;
    logic              match;
    logic              trig_hit;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_phys;

    // Channel mux; any select value without a matching channel falls back to channel 0.
    always_comb begin
        sel_word = probe_in[0 +: CH_W];
        for (int k = 1; k < int'(NUM_CH); k++) begin
            if (int'(ch_sel_q) == k) begin
                sel_word = probe_in[k*CH_W +: CH_W];
            end
        end
    end

    assign arm_start = arm && !abort && ((state_q == StIdle) || (state_q == StDone));

    // Sample stage; a sample taken before the arm latches ch_sel is discarded.
    always_ff @(posedge clk16x or negedge reset_n) begin
        if (!reset_n) begin
            sample_q   <= '0;
            samp_vld_q <= 1'b0;
            ext_q      <= 1'b0;
        end else begin
            sample_q   <= sel_word;
            ext_q      <= trig_ext;
            samp_vld_q <= sample_en && !arm_start && !abort;
        end
    end

    assign match    = ((sample_q & trig_mask) == (trig_value & trig_mask));
    assign trig_hit = trig_edge ? ((match && !match_prev_q) || ext_q) : (match || ext_q);

    always_comb begin
        state_d      = state_q;
        ch_sel_d     = ch_sel_q;
        pre_d        = pre_q;
        wr_ptr_d     = wr_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        post_cnt_d   = post_cnt_q;
        trig_ptr_d   = trig_ptr_q;
        triggered_d  = triggered_q;
        done_d       = done_q;
        match_prev_d = match_prev_q;
        wr_en        = 1'b0;

        if (abort) begin
            state_d     = StIdle;
            triggered_d = 1'b0;
            done_d      = 1'b0;
        end else if (arm_start) begin
            ch_sel_d     = ch_sel;
            pre_d        = pre_count;
            wr_ptr_d     = '0;
            fill_cnt_d   = '0;
            post_cnt_d   = '0;
            triggered_d  = 1'b0;
            done_d       = 1'b0;
            match_prev_d = 1'b0;
            state_d      = (pre_count != '0) ? StFill : StWait;
        end else if (samp_vld_q) begin
            case (state_q)
                StFill: begin
                    wr_en        = 1'b1;
                    wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
                    fill_cnt_d   = fill_cnt_q + ADDR_W'(1);
                    match_prev_d = match;
                    if (fill_cnt_q + ADDR_W'(1) == pre_q) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    wr_en        = 1'b1;
                    wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
                    match_prev_d = match;
                    if (trig_hit) begin
                        trig_ptr_d  = wr_ptr_q;
                        triggered_d = 1'b1;
                        post_cnt_d  = LastAddr - pre_q;
                        if (LastAddr == pre_q) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StPost;
                        end
                    end
                end
                StPost: begin
                    wr_en        = 1'b1;
                    wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
                    post_cnt_d   = post_cnt_q - ADDR_W'(1);
                    match_prev_d = match;
                    if (post_cnt_q == ADDR_W'(1)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk16x or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            ch_sel_q     <= '0;
            pre_q        <= '0;
            wr_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            post_cnt_q   <= '0;
            trig_ptr_q   <= '0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
            match_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_sel_q     <= ch_sel_d;
            pre_q        <= pre_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_cnt_q   <= fill_cnt_d;
            post_cnt_q   <= post_cnt_d;
            trig_ptr_q   <= trig_ptr_d;
            triggered_q  <= triggered_d;
            done_q       <= done_d;
            match_prev_q <= match_prev_d;
        end
    end

    always_ff @(posedge clk16x) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= sample_q;
        end
    end

    // Logical index 0 is the oldest sample: pre_count entries before the trigger.
    assign rd_phys = trig_ptr_q - pre_q + rd_addr;

    always_ff @(posedge clk16x or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (rd_en && (state_q == StDone)) begin
            rd_data_q  <= mem[rd_phys];
            rd_valid_q <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign state_o   = state_q;
    assign triggered = triggered_q;
    assign done      = done_q;
    assign trig_ptr  = trig_ptr_q;

endmodule

// File: tb/tb_debug_probe_capture.sv
// Scoreboard bench for debug_probe_capture: a sample-list model predicts the trigger index
// and window contents; a monitor pops expected read data whenever rd_valid is seen.
module tb_debug_probe_capture;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 16;
    localparam int SEL_W  = 2;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int MAXS   = 2048;

    logic                   clk16x  = 1'b0;
    logic                   reset_n = 1'b1;
    logic [NUM_CH*CH_W-1:0] probe_in;
    logic [SEL_W-1:0]       ch_sel;
    logic                   sample_en;
    logic                   arm;
    logic                   abort;
    logic                   trig_ext;
    logic [CH_W-1:0]        trig_mask;
    logic [CH_W-1:0]        trig_value;
    logic                   trig_edge;
    logic [ADDR_W-1:0]      pre_count;
    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr;
    logic [CH_W-1:0]        rd_data;
    logic                   rd_valid;
    logic [2:0]             state_o;
    logic                   triggered;
    logic                   done;
    logic [ADDR_W-1:0]      trig_ptr;

    debug_probe_capture #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .SEL_W(SEL_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk16x    (clk16x),
        .reset_n   (reset_n),
        .probe_in  (probe_in),
        .ch_sel    (ch_sel),
        .sample_en (sample_en),
        .arm       (arm),
        .abort     (abort),
        .trig_ext  (trig_ext),
        .trig_mask (trig_mask),
        .trig_value(trig_value),
        .trig_edge (trig_edge),
        .pre_count (pre_count),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .state_o   (state_o),
        .triggered (triggered),
        .done      (done),
        .trig_ptr  (trig_ptr)
    );

    typedef struct {
        logic [CH_W-1:0] data;
        int unsigned     due;
    } rd_exp_t;

    rd_exp_t         rd_q[$];
    int              n_cmp = 0;
    int              n_bad = 0;
    int unsigned     cyc   = 0;
    logic [CH_W-1:0] words [MAXS];
    bit              ext_at[MAXS];

    always #5 clk16x = ~clk16x;
    always @(posedge clk16x) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid must match the oldest outstanding read, on its due cycle.
    always @(negedge clk16x) begin
        rd_exp_t e;
        if (reset_n && rd_valid) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_valid_unexpected: got rd_valid=1 data=0x%0h, required no read pending",
                         rd_data);
            end else begin
                e = rd_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(e.data));
                check("rd_latency_cycle", cyc, e.due);
            end
        end
    end

    task automatic step();
        @(negedge clk16x);
    endtask

    task automatic set_probe(input logic [CH_W-1:0] w, input int ch);
        for (int k = 0; k < NUM_CH; k++) begin
            probe_in[k*CH_W +: CH_W] = (k == ch) ? w : CH_W'($urandom);
        end
    endtask

    task automatic fill_random_nomatch(input logic [CH_W-1:0] avoid);
        for (int n = 0; n < MAXS; n++) begin
            words[n] = CH_W'($urandom);
            if (words[n] == avoid) words[n] = words[n] ^ CH_W'(1);
            ext_at[n] = 1'b0;
        end
    endtask

    // Drives words[] on sample_en cycles after an arm; the model finds the trigger index from
    // the sample list and knows the capture ends DEPTH-1-pre samples after it.
    task automatic run_capture(input int ch, input int pre, input logic [CH_W-1:0] mask,
                               input logic [CH_W-1:0] value, input bit edge_m, input int period,
                               input bit noise_ext, input int rearm_at, input int stop_at,
                               input bit stop_rst, output int tidx, output bit completed);
        int n;
        bit prev;
        bit m;
        bit last;
        n = 0;
        prev = 1'b0;
        last = 1'b0;
        tidx = -1;
        completed = 1'b0;
        ch_sel = SEL_W'(ch);
        pre_count = ADDR_W'(pre);
        trig_mask = mask;
        trig_value = value;
        trig_edge = edge_m;
        sample_en = 1'b0;
        trig_ext = 1'b0;
        abort = 1'b0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        ch_sel = SEL_W'($urandom);
        pre_count = ADDR_W'($urandom);
        check("state_after_arm", 32'(state_o), (pre > 0) ? 32'd1 : 32'd2);
        check("triggered_after_arm", 32'(triggered), 32'd0);
        check("done_after_arm", 32'(done), 32'd0);
        for (int c = 0; c < MAXS * period && n < MAXS; c++) begin
            if (stop_at >= 0 && n == stop_at) begin
                sample_en = 1'b0;
                trig_ext = 1'b0;
                check("state_post_before_stop", 32'(state_o), 32'd3);
                check("triggered_in_post", 32'(triggered), 32'd1);
                if (!stop_rst) begin
                    abort = 1'b1;
                    step();
                    abort = 1'b0;
                    check("abort_state", 32'(state_o), 32'd0);
                    check("abort_done", 32'(done), 32'd0);
                    check("abort_triggered", 32'(triggered), 32'd0);
                    check("abort_trig_ptr_held", 32'(trig_ptr), 32'(tidx % DEPTH));
                end else begin
                    #2 reset_n = 1'b0;
                    #1;
                    check("rst_state", 32'(state_o), 32'd0);
                    check("rst_done", 32'(done), 32'd0);
                    check("rst_triggered", 32'(triggered), 32'd0);
                    check("rst_trig_ptr", 32'(trig_ptr), 32'd0);
                    check("rst_rd_valid", 32'(rd_valid), 32'd0);
                    check("rst_rd_data", 32'(rd_data), 32'd0);
                    step();
                    reset_n = 1'b1;
                end
                return;
            end
            if (c % period == 0) begin
                set_probe(words[n], ch);
                trig_ext = ext_at[n];
                sample_en = 1'b1;
                arm = (n == rearm_at);
                m = ((words[n] & mask) == (value & mask));
                if (tidx < 0 && n >= pre && ((edge_m ? (m && !prev) : m) || ext_at[n])) tidx = n;
                prev = m;
                last = (tidx >= 0 && n == tidx + DEPTH - 1 - pre);
                n++;
            end else begin
                set_probe(CH_W'($urandom), ch);
                trig_ext = noise_ext && ($urandom_range(0, 1) == 1);
                sample_en = 1'b0;
                arm = 1'b0;
            end
            step();
            if (last) begin
                sample_en = 1'b0;
                trig_ext = 1'b0;
                arm = 1'b0;
                check("not_done_before_last_write", 32'(state_o == 3'd4), 32'd0);
                step();
                check("state_done", 32'(state_o), 32'd4);
                check("done_flag", 32'(done), 32'd1);
                check("triggered_flag", 32'(triggered), 32'd1);
                check("trig_ptr", 32'(trig_ptr), 32'(tidx % DEPTH));
                completed = 1'b1;
                return;
            end
        end
        sample_en = 1'b0;
        arm = 1'b0;
        n_cmp++;
        n_bad++;
        $display("FAIL capture_timeout: got state_o=%0d after %0d samples, required DONE", state_o, n);
    endtask

    task automatic read_window(input int pre, input int tidx, input bit rand_addr,
                               input int n_reads);
        int r;
        for (int i = 0; i < n_reads; i++) begin
            r = rand_addr ? int'($urandom_range(0, DEPTH - 1)) : i;
            rd_en = 1'b1;
            rd_addr = ADDR_W'(r);
            rd_q.push_back('{data: words[tidx - pre + r], due: cyc + 1});
            step();
            if (rand_addr && $urandom_range(0, 3) == 0) begin
                rd_en = 1'b0;
                step();
            end
        end
        rd_en = 1'b0;
        step();
        step();
        check("read_queue_drained", 32'(rd_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  tidx;
        bit  ok;
        int  pre;
        logic [CH_W-1:0] mask;

        probe_in = '0; ch_sel = '0; sample_en = 1'b0; arm = 1'b0; abort = 1'b0;
        trig_ext = 1'b0; trig_mask = '0; trig_value = '0; trig_edge = 1'b0;
        pre_count = '0; rd_en = 1'b0; rd_addr = '0;

        #1 reset_n = 1'b0;
        #1;
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_triggered", 32'(triggered), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_trig_ptr", 32'(trig_ptr), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Counter on channel 2, level trigger at 0x0100 with 16 pre-trigger samples.
        for (int n = 0; n < MAXS; n++) begin
            words[n] = CH_W'(n);
            ext_at[n] = 1'b0;
        end
        run_capture(2, 16, 16'hFFFF, 16'h0100, 1'b0, 1, 1'b0, -1, -1, 1'b0, tidx, ok);
        if (ok) read_window(16, tidx, 1'b0, DEPTH);

        // Edge mode: match true from the start, low for samples 40..49, back at 50.
        for (int n = 0; n < MAXS; n++) begin
            if (n < 40 || n >= 50) words[n] = {8'hA5, 8'($urandom)};
            else words[n] = {8'(8'hA6 + 8'($urandom_range(0, 200))), 8'($urandom)};
            ext_at[n] = 1'b0;
        end
        run_capture(1, 8, 16'hFF00, 16'hA500, 1'b1, 1, 1'b0, -1, -1, 1'b0, tidx, ok);
        if (ok) read_window(8, tidx, 1'b1, 100);

        // Sparse sampling, pre=0, external trigger on the first sample; ext noise off-sample.
        fill_random_nomatch(16'hDEAD);
        ext_at[0] = 1'b1;
        run_capture(3, 0, 16'hFFFF, 16'hDEAD, 1'b0, 16, 1'b1, -1, -1, 1'b0, tidx, ok);
        if (ok) read_window(0, tidx, 1'b0, DEPTH);

        fill_random_nomatch(16'hDEAD);
        ext_at[5] = 1'b1;
        run_capture(0, 0, 16'hFFFF, 16'hDEAD, 1'b0, 4, 1'b1, -1, -1, 1'b0, tidx, ok);
        if (ok) read_window(0, tidx, 1'b1, 64);

        // Abort in POST, then arm+abort together, then an arm during WAIT.
        fill_random_nomatch(16'hDEAD);
        ext_at[10] = 1'b1;
        run_capture(0, 4, 16'hFFFF, 16'hDEAD, 1'b0, 1, 1'b0, -1, 60, 1'b0, tidx, ok);
        pre_count = 8'd3;
        arm = 1'b1;
        abort = 1'b1;
        step();
        arm = 1'b0;
        abort = 1'b0;
        check("arm_abort_state", 32'(state_o), 32'd0);
        step();
        check("arm_abort_state_hold", 32'(state_o), 32'd0);

        fill_random_nomatch(16'hDEAD);
        ext_at[100] = 1'b1;
        run_capture(2, 0, 16'hFFFF, 16'hDEAD, 1'b0, 1, 1'b0, 30, -1, 1'b0, tidx, ok);
        if (ok) read_window(0, tidx, 1'b0, DEPTH);

        // pre_count = 255: no post samples; logical index 255 is the trigger sample.
        words[0] = CH_W'($urandom);
        ext_at[0] = 1'b0;
        for (int n = 1; n < MAXS; n++) begin
            words[n] = words[n - 1] + CH_W'(1);
            ext_at[n] = 1'b0;
        end
        run_capture(1, 255, 16'hFFFF, words[300], 1'b0, 1, 1'b0, -1, -1, 1'b0, tidx, ok);
        if (ok) read_window(255, tidx, 1'b0, DEPTH);

        for (int it = 0; it < 4; it++) begin
            pre = int'($urandom_range(0, DEPTH - 1));
            mask = '0;
            repeat (3) mask[$urandom_range(0, CH_W - 1)] = 1'b1;
            for (int n = 0; n < MAXS; n++) begin
                words[n] = CH_W'($urandom);
                ext_at[n] = ($urandom_range(0, 299) == 0) || (n == pre + 400);
            end
            run_capture(int'($urandom_range(0, NUM_CH - 1)), pre, mask, CH_W'($urandom),
                        bit'($urandom_range(0, 1)), int'($urandom_range(1, 3)), 1'b0, -1, -1,
                        1'b0, tidx, ok);
            if (ok) read_window(pre, tidx, 1'b1, 64);
        end

        // Reset mid-POST, then reads in IDLE must not produce rd_valid.
        fill_random_nomatch(16'hDEAD);
        ext_at[20] = 1'b1;
        run_capture(3, 2, 16'hFFFF, 16'hDEAD, 1'b0, 1, 1'b0, -1, 100, 1'b1, tidx, ok);
        rd_en = 1'b1;
        rd_addr = ADDR_W'($urandom);
        step();
        check("idle_read_valid", 32'(rd_valid), 32'd0);
        check("idle_state", 32'(state_o), 32'd0);
        step();
        check("idle_read_valid_2", 32'(rd_valid), 32'd0);
        rd_en = 1'b0;
        step();
        check("final_queue_empty", 32'(rd_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
